// File: rtl/conv_y_sink_if.sv
// Y-sample stream between the convolution engine (master) and a receiving sink (slave).
// Carries the valid/ready handshake and the signed sample.
interface conv_y_sink_if #(
    parameter int ACC_SIZE = 21
);
    logic                       s_valid_y;
    logic signed [ACC_SIZE-1:0] s_data_in_y;
    logic                       s_ready_y;

    modport master (
        output s_valid_y,
        output s_data_in_y,
        input  s_ready_y
    );

    modport slave (
        input  s_valid_y,
        input  s_data_in_y,
        output s_ready_y
    );
endinterface

// File: rtl/conv_y_sink.sv
// Captures one convolution output frame into a buffer, tracks its signed sum and maximum,
// and offers the frozen frame through a registered random-access read port.
module conv_y_sink #(
    parameter int ACC_SIZE   = 21,
    parameter int X_SIZE     = 128,
    parameter int F_SIZE     = 32,
    parameter int Y_COUNT    = X_SIZE - F_SIZE + 1,
    parameter int ADDR_WIDTH = $clog2(Y_COUNT),
    parameter int SUM_WIDTH  = ACC_SIZE + ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    conv_y_sink_if.slave                y,
    output logic                        frame_done,
    input  logic                        frame_clear,
    input  logic                        rd_req,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic                        rd_valid,
    output logic signed [ACC_SIZE-1:0]  rd_data,
    output logic                        rd_err,
    output logic signed [SUM_WIDTH-1:0] frame_sum,
    output logic signed [ACC_SIZE-1:0]  frame_max,
    output logic [7:0]                  frame_cnt
);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    localparam logic signed [ACC_SIZE-1:0] MAX_INIT = {1'b1, {(ACC_SIZE-1){1'b0}}};

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_WIDTH-1:0]      wr_cnt;
    logic signed [ACC_SIZE-1:0] y_buf [Y_COUNT];

    logic                       xfer;
    logic                       last;
    logic                       rd_fire;
    logic                       rd_in_range;
    logic signed [SUM_WIDTH-1:0] sample_ext;

    assign y.s_ready_y  = (state == COLLECT);
    assign frame_done   = (state == HOLD);
    assign xfer         = y.s_valid_y && y.s_ready_y;
    assign last         = (wr_cnt == ADDR_WIDTH'(Y_COUNT - 1));
    assign rd_fire      = rd_req && (state == HOLD);
    assign rd_in_range  = ({1'b0, rd_addr} < (ADDR_WIDTH + 1)'(Y_COUNT));
    assign sample_ext   = {{(SUM_WIDTH - ACC_SIZE){y.s_data_in_y[ACC_SIZE-1]}}, y.s_data_in_y};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // A clear wins over a simultaneous last transfer: the sample is dropped, so no HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (!frame_clear && xfer && last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (frame_clear) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt    <= '0;
            frame_sum <= '0;
            frame_max <= MAX_INIT;
            frame_cnt <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
        end else begin
            if (frame_clear) begin
                wr_cnt    <= '0;
                frame_sum <= '0;
                frame_max <= MAX_INIT;
            end else if (xfer) begin
                wr_cnt    <= last ? '0 : wr_cnt + 1'b1;
                frame_sum <= frame_sum + sample_ext;
                if (y.s_data_in_y > frame_max) begin
                    frame_max <= y.s_data_in_y;
                end
                if (last) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end

            rd_valid <= rd_fire;
            rd_err   <= rd_fire && !rd_in_range;
            if (rd_fire) begin
                rd_data <= rd_in_range ? y_buf[rd_addr] : '0;
            end
        end
    end

    // Frame storage carries no reset; contents only matter once a frame is complete.
    always_ff @(posedge clk) begin
        if (xfer && !frame_clear) begin
            y_buf[wr_cnt] <= y.s_data_in_y;
        end
    end

endmodule

// File: tb/tb_conv_y_sink.sv
// Directed bench for conv_y_sink: frame capture, running sum/max, read port, clears,
// asynchronous reset and frame counter wrap.
module tb_conv_y_sink;

    localparam int  YC   = 97;
    localparam longint MINV = -1048576;

    logic               clk;
    logic               reset;
    logic               frame_done;
    logic               frame_clear;
    logic               rd_req;
    logic [6:0]         rd_addr;
    logic               rd_valid;
    logic signed [20:0] rd_data;
    logic               rd_err;
    logic signed [27:0] frame_sum;
    logic signed [20:0] frame_max;
    logic [7:0]         frame_cnt;

    conv_y_sink_if #(.ACC_SIZE(21)) y_if ();

    conv_y_sink #(
        .ACC_SIZE (21),
        .X_SIZE   (128),
        .F_SIZE   (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .y           (y_if),
        .frame_done  (frame_done),
        .frame_clear (frame_clear),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_err      (rd_err),
        .frame_sum   (frame_sum),
        .frame_max   (frame_max),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    longint ref_mem [YC];
    longint ref_sum;
    longint ref_max;

    typedef struct {
        logic               req;
        logic [6:0]         addr;
        logic               exp_valid;
        logic signed [20:0] exp_data;
        logic               exp_err;
    } rd_vec_t;

    rd_vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty_frame(input string tag);
        check({tag, "_ready"}, y_if.s_ready_y, 1);
        check({tag, "_done"},  frame_done, 0);
        check({tag, "_sum"},   frame_sum, 0);
        check({tag, "_max"},   frame_max, MINV);
    endtask

    // One sample, preceded by `gap` idle cycles; the sink must already be ready.
    task automatic send_sample(input longint v, input int gap, input int idx);
        repeat (gap) begin
            y_if.s_valid_y = 1'b0;
            step();
        end
        check("ready_at_xfer", y_if.s_ready_y, 1);
        y_if.s_valid_y   = 1'b1;
        y_if.s_data_in_y = 21'(v);
        ref_mem[idx] = v;
        ref_sum += v;
        if (v > ref_max) ref_max = v;
        step();
        y_if.s_valid_y = 1'b0;
    endtask

    task automatic read_sweep(input string tag);
        for (int a = 0; a < YC; a++) begin
            rd_req  = 1'b1;
            rd_addr = 7'(a);
            step();
            check({tag, "_rd_valid"}, rd_valid, 1);
            check({tag, "_rd_data"},  rd_data, ref_mem[a]);
            check({tag, "_rd_err"},   rd_err, 0);
        end
        rd_req = 1'b0;
    endtask

    task automatic quick_frame();
        y_if.s_valid_y = 1'b1;
        for (int i = 0; i < YC; i++) begin
            y_if.s_data_in_y = 21'(i);
            step();
        end
        y_if.s_valid_y = 1'b0;
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 7'd0,   1'b1, -21'sd48, 1'b0};
        vecs[1] = '{1'b1, 7'd96,  1'b1,  21'sd48, 1'b0};
        vecs[2] = '{1'b1, 7'd48,  1'b1,  21'sd0,  1'b0};
        vecs[3] = '{1'b1, 7'd97,  1'b1,  21'sd0,  1'b1};
        vecs[4] = '{1'b1, 7'd10,  1'b1, -21'sd38, 1'b0};
        vecs[5] = '{1'b0, 7'd5,   1'b0, -21'sd38, 1'b0};
        vecs[6] = '{1'b1, 7'd100, 1'b1,  21'sd0,  1'b1};
        vecs[7] = '{1'b1, 7'd127, 1'b1,  21'sd0,  1'b1};

        reset            = 1'b0;
        y_if.s_valid_y   = 1'b0;
        y_if.s_data_in_y = '0;
        frame_clear      = 1'b0;
        rd_req           = 1'b0;
        rd_addr          = '0;

        #12;
        check_empty_frame("reset");
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data",  rd_data, 0);
        check("reset_rd_err",   rd_err, 0);
        check("reset_cnt",      frame_cnt, 0);
        #5 reset = 1'b1;
        step();
        check("release_ready", y_if.s_ready_y, 1);

        // Frame 1: back-to-back ramp -48..48.
        ref_sum = 0;
        ref_max = MINV;
        y_if.s_valid_y = 1'b1;
        for (int i = 0; i < YC; i++) begin
            y_if.s_data_in_y = 21'(i - 48);
            ref_mem[i] = i - 48;
            if (i == YC - 1) check("ramp_ready_last", y_if.s_ready_y, 1);
            step();
            if (i == YC - 2) check("ramp_done_early", frame_done, 0);
        end
        y_if.s_valid_y = 1'b0;
        check("ramp_ready_low", y_if.s_ready_y, 0);
        check("ramp_done",      frame_done, 1);
        check("ramp_cnt",       frame_cnt, 1);
        check("ramp_sum",       frame_sum, 0);
        check("ramp_max",       frame_max, 48);

        for (int v = 0; v < 8; v++) begin
            rd_req  = vecs[v].req;
            rd_addr = vecs[v].addr;
            step();
            check($sformatf("vec%0d_rd_valid", v), rd_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_rd_data", v),  rd_data, vecs[v].exp_data);
            check($sformatf("vec%0d_rd_err", v),   rd_err, vecs[v].exp_err);
        end
        rd_req = 1'b0;
        read_sweep("ramp");

        // Valid held high in HOLD must not write anything.
        y_if.s_valid_y   = 1'b1;
        y_if.s_data_in_y = 21'sd7;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_ready", y_if.s_ready_y, 0);
            check("hold_sum",   frame_sum, 0);
        end
        y_if.s_valid_y = 1'b0;
        check("hold_max", frame_max, 48);
        read_sweep("hold");

        // Clear together with a read: old data served, state back to COLLECT.
        frame_clear = 1'b1;
        rd_req      = 1'b1;
        rd_addr     = 7'd5;
        step();
        frame_clear = 1'b0;
        rd_req      = 1'b0;
        check("clrrd_rd_valid", rd_valid, 1);
        check("clrrd_rd_data",  rd_data, -43);
        check_empty_frame("clrrd");

        rd_req  = 1'b1;
        rd_addr = 7'd20;
        step();
        rd_req = 1'b0;
        check("collect_rd_valid", rd_valid, 0);
        check("collect_rd_hold",  rd_data, -43);

        // Partial frame of 40, then discard (with a colliding transfer that must be dropped).
        ref_sum = 0;
        ref_max = MINV;
        for (int i = 0; i < 40; i++) send_sample(1000 + i, 0, i);
        check("partial_sum", frame_sum, 40780);
        check("partial_max", frame_max, 1039);
        frame_clear      = 1'b1;
        y_if.s_valid_y   = 1'b1;
        y_if.s_data_in_y = 21'sd999;
        step();
        frame_clear    = 1'b0;
        y_if.s_valid_y = 1'b0;
        check_empty_frame("midclr");

        // Full frame with random gaps and extreme values.
        ref_sum = 0;
        ref_max = MINV;
        for (int i = 0; i < YC; i++) begin
            longint v;
            case ($urandom_range(0, 2))
                0:       v = 1048575;
                1:       v = -1048575;
                default: v = longint'($urandom_range(0, 2097150)) - 1048575;
            endcase
            send_sample(v, int'($urandom_range(0, 3)), i);
        end
        check("rand_done", frame_done, 1);
        check("rand_cnt",  frame_cnt, 2);
        check("rand_sum",  frame_sum, ref_sum);
        check("rand_max",  frame_max, ref_max);
        read_sweep("rand");

        // Asynchronous reset between clock edges, mid-frame.
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        for (int i = 0; i < 20; i++) send_sample(i + 1, 0, i);
        #3;
        reset = 1'b0;
        #1;
        check_empty_frame("areset");
        check("areset_cnt",      frame_cnt, 0);
        check("areset_rd_data",  rd_data, 0);
        check("areset_rd_valid", rd_valid, 0);
        check("areset_rd_err",   rd_err, 0);
        step();
        step();
        #2 reset = 1'b1;
        step();
        check("arelease_ready", y_if.s_ready_y, 1);

        for (int f = 1; f <= 256; f++) begin
            quick_frame();
            if (f == 1)   check("wrap_cnt1",   frame_cnt, 1);
            if (f == 255) check("wrap_cnt255", frame_cnt, 255);
        end
        check("wrap_cnt0", frame_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/conv_y_sink.md
Name: conv_y_sink

Overview:
- Receive end of the convolution output stream: accepts Y samples over the valid/ready handshake and captures one complete output frame (X_SIZE-F_SIZE+1 samples) into an internal buffer.
- Keeps a running signed sum and maximum of each frame.
- Exposes the captured frame through a registered random-access read port, for bench self-checking and host readback.
- Sits directly downstream of the convolution engine's Y master port.

Parameters:
- ACC_SIZE, 21, width of each signed Y sample
- X_SIZE, 128, X vector length used by the upstream convolution
- F_SIZE, 32, filter length used by the upstream convolution
- Y_COUNT, X_SIZE-F_SIZE+1 (97), samples per frame
- ADDR_WIDTH, $clog2(Y_COUNT) (7), buffer address width
- SUM_WIDTH, ACC_SIZE+ADDR_WIDTH (28), frame sum width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset: 0 resets immediately, 1 runs
- s_valid_y  in  1  upstream Y sample valid
- s_data_in_y  in  ACC_SIZE  signed Y sample
- s_ready_y  out  1  sink can accept a sample
- frame_done  out  1  complete frame captured; buffer frozen
- frame_clear  in  1  one-cycle request to discard the buffer and rearm capture
- rd_req  in  1  read request (honoured only while frame_done=1)
- rd_addr  in  ADDR_WIDTH  read address
- rd_valid  out  1  rd_data valid, one-cycle pulse
- rd_data  out  ACC_SIZE  signed read data
- rd_err  out  1  pulse with rd_valid when rd_addr >= Y_COUNT
- frame_sum  out  SUM_WIDTH  signed sum of accepted samples in the current frame
- frame_max  out  ACC_SIZE  signed maximum of accepted samples in the current frame
- frame_cnt  out  8  completed frames since reset; wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT, wr_cnt=0.
  - s_ready_y=1 after release; frame_done=0.
  - rd_valid=0, rd_data=0, rd_err=0.
  - frame_sum=0, frame_max=most-negative ACC_SIZE value, frame_cnt=0.
  - Buffer contents are undefined.
- FSM: COLLECT, HOLD. s_ready_y = (state==COLLECT); frame_done = (state==HOLD). Both decode state combinationally.
- COLLECT:
  - A transfer occurs on each cycle with s_valid_y && s_ready_y.
  - On a transfer: buf[wr_cnt]<=s_data_in_y and wr_cnt++.
  - frame_sum += sign-extended sample; no overflow is possible at these widths.
  - frame_max updates if the sample is strictly greater.
- Last sample: a transfer with wr_cnt==Y_COUNT-1 moves the FSM to HOLD on the same edge and increments frame_cnt.
  - s_ready_y is 0 from the next cycle on.
  - No throughput gap inside a frame: back-to-back valids are accepted every cycle.
- HOLD:
  - No writes; s_valid_y is ignored and data is held upstream by s_ready_y=0.
  - frame_sum and frame_max are stable.
- Read port:
  - A rd_req in HOLD gives rd_valid=1 on the next cycle, with rd_data=buf[rd_addr].
  - If rd_addr>=Y_COUNT: rd_data=0 and rd_err=1.
  - One read per cycle, fully pipelined.
  - rd_req in COLLECT is ignored: rd_valid stays 0.
  - rd_data holds its last value when rd_valid=0.
- frame_clear in HOLD: next state COLLECT; wr_cnt, frame_sum and frame_max return to their reset values. Buffer contents are not erased.
- frame_clear in COLLECT: the partial frame is discarded and wr_cnt, frame_sum, frame_max are cleared.
  - If a transfer occurs in the same cycle, that sample is dropped.
  - s_ready_y stays 1.
- Simultaneous frame_clear and rd_req in HOLD: the read is served from the old frame on the next cycle; the state returns to COLLECT.
- Reset mid-frame aborts immediately; all registers take their reset values.

Test Plan:
- Reset, then drive 97 back-to-back samples y[i]=i-48 -> s_ready_y falls the cycle after the 97th transfer.
  - frame_done=1, frame_cnt=1, frame_sum=0, frame_max=48.
  - Reading addresses 0..96 returns -48..48 with 1-cycle latency.
- Random s_valid_y gaps with values of ±(2^20-1) -> the stored frame matches the accepted sequence exactly.
  - frame_sum equals the reference sum; no sample is lost or duplicated.
- In HOLD, hold s_valid_y=1 for 10 cycles with value 7 -> no writes, frame_sum unchanged.
  - After frame_clear, the next transfer lands at address 0.
- Read rd_addr=100 in HOLD -> rd_valid=1, rd_err=1, rd_data=0.
  - rd_req in COLLECT -> rd_valid stays 0.
- Assert frame_clear after 40 transfers -> wr_cnt restarts at 0 and frame_sum=0.
  - A full 97-sample frame then completes normally; frame_cnt increments by exactly 1.
- Assert reset=0 asynchronously mid-frame, between clock edges -> outputs take their reset values immediately; s_ready_y=1 after release.
  - Run 256 complete frames -> frame_cnt wraps to 0.
